rx_lane_align_demux: RTL and testbench

//  Per-channel word aligner plus width-gearbox for a multi-channel LVDS source-synchronous receiver.
//  - Sits between the LVDS deserializer megafunction and the user logic, in the rx_outclock domain.
//  - Trains each channel on a fixed pattern, issuing bitslip (channel_data_align) pulses until the word locks.
//  - Once every channel is locked, packs 1, 2 or 4 consecutive deserialized words per channel into a wide

---
 rtl/rx_align_pkg.sv | 38 +++
 rtl/rx_align_lane.sv | 118 +++++++++++
 rtl/rx_lane_align_demux.sv | 153 +++++++++++++++
 tb/tb_rx_lane_align_demux.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_align_pkg.sv
// rx_align_pkg
//   Shared types and helpers for the LVDS receive word aligner / gearbox.
//   - lane_state_e : per-lane training state machine encoding.
//   - pack_ratio() : decodes the 2-bit pack-mode select into the number of
//                    words gathered per output beat, clamped to the
//                    build-time maximum.
package rx_align_pkg;

    typedef enum logic [2:0] {
        LANE_IDLE   = 3'd0,
        LANE_CHECK  = 3'd1,
        LANE_SLIP   = 3'd2,
        LANE_WAIT   = 3'd3,
        LANE_LOCKED = 3'd4,
        LANE_FAIL   = 3'd5
    } lane_state_e;

    localparam int NCH_DEF       = 20;
    localparam int DESER_DEF     = 10;
    localparam int RATIO_DEF     = 4;
    localparam int LOCK_CNT_DEF  = 8;
    localparam int SLIP_WAIT_DEF = 4;

    // sel 0 -> 1 word, 1 -> 2 words, 2/3 -> 4 words; never above ratio.
    function automatic int pack_ratio(input logic [1:0] sel, input int ratio);
        int r;
        case (sel)
            2'd0:    r = 1;
            2'd1:    r = 2;
            default: r = 4;
        endcase
        if (r > ratio) begin
            r = ratio;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_align_lane.sv
// rx_lane_align
//   Word-alignment FSM for one LVDS channel. Compares each deserialized word
//   with the training pattern; on a mismatch it requests one bitslip from the
//   SERDES, waits out the slip latency, and checks again. Declares lock after
//   LOCK_CNT consecutive matches, or failure after DESER slips without lock.
// Ports
//   clk_i     deserializer output clock
//   rst_n_i   asynchronous active-low reset
//   rdy_i     deserializer ready; low forces the lane back to IDLE
//   train_i   restart alignment (IDLE on the next cycle)
//   word_i    deserialized word of this channel
//   cda_o     one-cycle bitslip request
//   locked_o  lane aligned
//   fail_o    lane gave up after DESER slips
module rx_lane_align
    import rx_align_pkg::*;
#(
    parameter int               DESER     = DESER_DEF,
    parameter logic [DESER-1:0] TRAIN_PAT = 10'h0F8,
    parameter int               LOCK_CNT  = LOCK_CNT_DEF,
    parameter int               SLIP_WAIT = SLIP_WAIT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rdy_i,
    input  logic             train_i,
    input  logic [DESER-1:0] word_i,
    output logic             cda_o,
    output logic             locked_o,
    output logic             fail_o
);

    localparam int SW = $clog2(DESER + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    lane_state_e   state_q;
    logic [SW-1:0] slips_q;
    logic [MW-1:0] match_q;
    logic [WW-1:0] wait_q;
    logic          cda_q;
    logic          locked_q;
    logic          fail_q;

    // The bitslip request is raised on entry to SLIP, so it is high for
    // exactly the SLIP cycle. An abort during SLIP therefore cannot shorten
    // or repeat the pulse: it has already been issued in full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= LANE_IDLE;
            slips_q  <= '0;
            match_q  <= '0;
            wait_q   <= '0;
            cda_q    <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            cda_q <= 1'b0;
            // Loss of ready outranks a training request; both restart the lane.
            if (!rdy_i || train_i) begin
                state_q  <= LANE_IDLE;
                locked_q <= 1'b0;
                fail_q   <= 1'b0;
            end else begin
                case (state_q)
                    LANE_IDLE: begin
                        match_q  <= '0;
                        slips_q  <= '0;
                        locked_q <= 1'b0;
                        fail_q   <= 1'b0;
                        state_q  <= LANE_CHECK;
                    end
                    LANE_CHECK: begin
                        if (word_i == TRAIN_PAT) begin
                            if (match_q == MW'(LOCK_CNT - 1)) begin
                                state_q  <= LANE_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                match_q <= match_q + 1'b1;
                            end
                        end else begin
                            match_q <= '0;
                            if (slips_q < SW'(DESER)) begin
                                state_q <= LANE_SLIP;
                                cda_q   <= 1'b1;
                                slips_q <= slips_q + 1'b1;
                            end else begin
                                state_q <= LANE_FAIL;
                                fail_q  <= 1'b1;
                            end
                        end
                    end
                    LANE_SLIP: begin
                        wait_q  <= '0;
                        state_q <= LANE_WAIT;
                    end
                    LANE_WAIT: begin
                        // Words arriving during the SERDES slip latency are
                        // unreliable and are not compared.
                        if (wait_q == WW'(SLIP_WAIT - 1)) begin
                            state_q <= LANE_CHECK;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    LANE_LOCKED: state_q <= LANE_LOCKED;
                    LANE_FAIL:   state_q <= LANE_FAIL;
                    default:     state_q <= LANE_IDLE;
                endcase
            end
        end
    end

    assign cda_o    = cda_q;
    assign locked_o = locked_q;
    assign fail_o   = fail_q;

endmodule

// File: rtl/rx_lane_align_demux.sv
// rx_lane_align_demux
//   Per-channel word aligner plus width gearbox for a multi-channel LVDS
//   source-synchronous receiver, in the deserializer output clock domain.
//   Each channel trains independently; once all are locked, 1, 2 or 4
//   consecutive words per channel are packed into one wide beat with a
//   common valid strobe. All channels share one gather counter so beats stay
//   word-aligned across channels.
// Ports
//   I_clk         deserializer output clock
//   I_rst_n       asynchronous active-low reset
//   I_sel         pack mode: 0=1 word, 1=2 words, 2/3=4 words (clamped)
//   I_rx_cda_rdy  deserializer ready; low returns every lane to IDLE
//   I_train       one-cycle pulse restarting alignment on all lanes
//   I_rx_data     channel c word at [c*DESER +: DESER]
//   O_cda         per-lane bitslip pulse
//   O_locked      per-lane locked
//   O_fail        per-lane alignment failure
//   O_all_locked  every lane locked
//   O_valid       one-cycle strobe: O_data holds a complete beat
//   O_data        channel c beat at [c*DESER*RATIO +: DESER*RATIO]
module rx_lane_align_demux
    import rx_align_pkg::*;
#(
    parameter int               NCH       = NCH_DEF,
    parameter int               DESER     = DESER_DEF,
    parameter int               RATIO     = RATIO_DEF,
    parameter logic [DESER-1:0] TRAIN_PAT = 10'h0F8,
    parameter int               LOCK_CNT  = LOCK_CNT_DEF,
    parameter int               SLIP_WAIT = SLIP_WAIT_DEF
) (
    input  logic                       I_clk,
    input  logic                       I_rst_n,
    input  logic [1:0]                 I_sel,
    input  logic                       I_rx_cda_rdy,
    input  logic                       I_train,
    input  logic [NCH*DESER-1:0]       I_rx_data,
    output logic [NCH-1:0]             O_cda,
    output logic [NCH-1:0]             O_locked,
    output logic [NCH-1:0]             O_fail,
    output logic                       O_all_locked,
    output logic                       O_valid,
    output logic [NCH*DESER*RATIO-1:0] O_data
);

    localparam int BEAT = DESER * RATIO;
    localparam int KW   = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [NCH-1:0]       lane_cda;
    logic [NCH-1:0]       lane_locked;
    logic [NCH-1:0]       lane_fail;

    logic                 all_locked_q;
    logic                 valid_q;
    logic [NCH*BEAT-1:0]  data_q;
    logic [1:0]           sel_q;
    logic [KW-1:0]        k_q;
    logic [KW-1:0]        k_d;

    logic                 sel_chg;
    logic                 gather_en;
    logic                 beat_last;
    logic [KW-1:0]        last_k;
    int                   r_words;
    logic [NCH*BEAT-1:0]  beat_d;

    // ---------------------------------------------------------------- lanes
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
        rx_lane_align #(
            .DESER     (DESER),
            .TRAIN_PAT (TRAIN_PAT),
            .LOCK_CNT  (LOCK_CNT),
            .SLIP_WAIT (SLIP_WAIT)
        ) u_lane (
            .clk_i    (I_clk),
            .rst_n_i  (I_rst_n),
            .rdy_i    (I_rx_cda_rdy),
            .train_i  (I_train),
            .word_i   (I_rx_data[gi*DESER +: DESER]),
            .cda_o    (lane_cda[gi]),
            .locked_o (lane_locked[gi]),
            .fail_o   (lane_fail[gi])
        );
    end

    // -------------------------------------------------------------- gearbox
    // The pack mode in force is the registered one; a differing input marks
    // a mode change, which drops the partial beat including the current word.
    assign sel_chg = (I_sel != sel_q);

    always_comb begin
        r_words = pack_ratio(sel_q, RATIO);
        last_k  = KW'(r_words - 1);
    end

    // Ready loss and training stop gathering at once rather than waiting for
    // the lock flags to fall, so no beat is built from untrained data.
    assign gather_en = all_locked_q & I_rx_cda_rdy & ~I_train & ~sel_chg;
    assign beat_last = gather_en & (k_q == last_k);

    always_comb begin
        k_d = k_q;
        if (!gather_en || beat_last) begin
            k_d = '0;
        end else begin
            k_d = k_q + 1'b1;
        end
    end

    // Per channel: words 0..k-1 of the beat come from the gather buffer, the
    // word arriving now completes it; slots at or above the pack ratio are 0.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
        logic [DESER-1:0] buf_q [RATIO];

        always_ff @(posedge I_clk) begin
            if (gather_en) begin
                buf_q[k_q] <= I_rx_data[gi*DESER +: DESER];
            end
        end

        for (genvar gw = 0; gw < RATIO; gw++) begin : g_word
            assign beat_d[gi*BEAT + gw*DESER +: DESER] =
                (gw >= r_words)      ? '0 :
                (KW'(gw) == k_q)     ? I_rx_data[gi*DESER +: DESER] :
                                       buf_q[gw];
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            all_locked_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            sel_q        <= 2'd0;
            k_q          <= '0;
        end else begin
            all_locked_q <= I_rx_cda_rdy & ~I_train & (&lane_locked);
            valid_q      <= beat_last;
            sel_q        <= I_sel;
            k_q          <= k_d;
            if (beat_last) begin
                data_q <= beat_d;
            end
        end
    end

    assign O_cda        = lane_cda;
    assign O_locked     = lane_locked;
    assign O_fail       = lane_fail;
    assign O_all_locked = all_locked_q;
    assign O_valid      = valid_q;
    assign O_data       = data_q;

endmodule

// File: tb/tb_rx_lane_align_demux.sv
module tb_rx_lane_align_demux;

    localparam int NCH       = 20;
    localparam int DESER     = 10;
    localparam int RATIO     = 4;
    localparam int LOCK_CNT  = 8;
    localparam int SLIP_WAIT = 4;
    localparam int BEAT      = DESER * RATIO;
    localparam logic [DESER-1:0] PAT = 10'h0F8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [1:0]              sel = 2'd0;
    logic                    rdy = 1'b0;
    logic                    train = 1'b0;
    logic [NCH*DESER-1:0]    rx_data = '0;
    logic [NCH-1:0]          o_cda;
    logic [NCH-1:0]          o_locked;
    logic [NCH-1:0]          o_fail;
    logic                    o_all_locked;
    logic                    o_valid;
    logic [NCH*BEAT-1:0]     o_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference gearbox: words of the current beat queue up as whole-bus
    // snapshots; a beat is emitted when the queue holds R of them.
    logic [NCH*DESER-1:0] mdl_q[$];
    int                   mdl_sel_prev = 0;
    bit                   mdl_all_locked = 1'b0;
    bit                   mdl_valid = 1'b0;
    logic [NCH*BEAT-1:0]  mdl_data = '0;

    always #5 clk = ~clk;

    rx_lane_align_demux #(
        .NCH(NCH), .DESER(DESER), .RATIO(RATIO), .TRAIN_PAT(PAT),
        .LOCK_CNT(LOCK_CNT), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_sel        (sel),
        .I_rx_cda_rdy (rdy),
        .I_train      (train),
        .I_rx_data    (rx_data),
        .O_cda        (o_cda),
        .O_locked     (o_locked),
        .O_fail       (o_fail),
        .O_all_locked (o_all_locked),
        .O_valid      (o_valid),
        .O_data       (o_data)
    );

    function automatic logic [DESER-1:0] rotr(input logic [DESER-1:0] v, input int r);
        logic [2*DESER-1:0] d;
        d = {v, v};
        return d[r +: DESER];
    endfunction

    function automatic int ratio_of(input int s);
        int r;
        r = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        return (r > RATIO) ? RATIO : r;
    endfunction

    task automatic set_lane(input int c, input logic [DESER-1:0] w);
        rx_data[c*DESER +: DESER] = w;
    endtask

    task automatic all_pat();
        for (int c = 0; c < NCH; c++) set_lane(c, PAT);
    endtask

    task automatic all_rand();
        for (int c = 0; c < NCH; c++) set_lane(c, DESER'($urandom));
    endtask

    // One clock: advance the reference with the inputs about to be sampled,
    // then compare valid/data just after the edge.
    task automatic tick();
        bit en;
        int r;
        logic [NCH*DESER-1:0] snap;
        en = mdl_all_locked && rdy && !train && (int'(sel) == mdl_sel_prev);
        r = ratio_of(mdl_sel_prev);
        mdl_valid = 1'b0;
        if (en) begin
            mdl_q.push_back(rx_data);
            if (mdl_q.size() == r) begin
                mdl_valid = 1'b1;
                mdl_data = '0;
                for (int w = 0; w < r; w++) begin
                    snap = mdl_q[w];
                    for (int c = 0; c < NCH; c++)
                        mdl_data[c*BEAT + w*DESER +: DESER] = snap[c*DESER +: DESER];
                end
                mdl_q.delete();
            end
        end else begin
            mdl_q.delete();
        end
        mdl_sel_prev = int'(sel);
        @(posedge clk);
        #1;
        n_tests++;
        if (o_valid !== mdl_valid) begin
            n_fail++;
            $display("FAIL valid @%0t: got %b want %b", $time, o_valid, mdl_valid);
        end
        n_tests++;
        if (o_data !== mdl_data) begin
            n_fail++;
            for (int c = 0; c < NCH; c++) begin
                if (o_data[c*BEAT +: BEAT] !== mdl_data[c*BEAT +: BEAT]) begin
                    $display("FAIL data @%0t ch%0d: got %h want %h", $time, c,
                             o_data[c*BEAT +: BEAT], mdl_data[c*BEAT +: BEAT]);
                    break;
                end
            end
        end
    endtask

    task automatic pulse_train();
        train = 1'b1;
        tick();
        train = 1'b0;
        mdl_all_locked = 1'b0;
        n_tests++;
        if (o_locked !== '0 || o_fail !== '0 || o_all_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL train_clear: locked %h fail %h all %b want 0", o_locked, o_fail, o_all_locked);
        end
    endtask

    // Lanes start in IDLE; pattern on every lane: one cycle to enter CHECK,
    // LOCK_CNT matches to lock, one more for the aggregate flag.
    task automatic run_lock(input string tag);
        logic [NCH-1:0] exp_l;
        rdy = 1'b1;
        train = 1'b0;
        all_pat();
        for (int n = 1; n <= LOCK_CNT + 3; n++) begin
            tick();
            exp_l = (n >= LOCK_CNT + 1) ? '1 : '0;
            n_tests++;
            if (o_cda !== '0) begin
                n_fail++;
                $display("FAIL %s cda n=%0d: got %h want 0", tag, n, o_cda);
            end
            n_tests++;
            if (o_locked !== exp_l || o_fail !== '0) begin
                n_fail++;
                $display("FAIL %s locked n=%0d: got %h fail %h want %h", tag, n, o_locked, o_fail, exp_l);
            end
            n_tests++;
            if (o_all_locked !== (n >= LOCK_CNT + 2)) begin
                n_fail++;
                $display("FAIL %s all_locked n=%0d: got %b want %b", tag, n, o_all_locked, n >= LOCK_CNT + 2);
            end
            if (n == LOCK_CNT + 2) mdl_all_locked = 1'b1;
        end
        $display("[TB] %s: lock sequence done", tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy = 1'b0;
        all_pat();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (o_cda !== '0 || o_locked !== '0 || o_fail !== '0) begin
            n_fail++;
            $display("FAIL reset_lanes: cda %h locked %h fail %h want 0", o_cda, o_locked, o_fail);
        end
        n_tests++;
        if (o_all_locked !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: all %b valid %b want 0", o_all_locked, o_valid);
        end
        n_tests++;
        if (o_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got nonzero want 0");
        end
        rst_n = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_pack4();
        logic [BEAT-1:0] exp_b;
        int nv;
        exp_b = {10'h004, 10'h003, 10'h002, 10'h001};
        sel = 2'd2;
        all_rand();
        tick();
        for (int w = 1; w <= 4; w++) begin
            all_rand();
            set_lane(0, DESER'(w));
            tick();
        end
        n_tests++;
        if (o_valid !== 1'b1 || o_data[BEAT-1:0] !== exp_b) begin
            n_fail++;
            $display("FAIL pack4_lane0: valid %b data %h want 1 %h", o_valid, o_data[BEAT-1:0], exp_b);
        end
        nv = 0;
        for (int t = 0; t < 12; t++) begin
            all_rand();
            tick();
            if (o_valid) nv++;
        end
        n_tests++;
        if (nv != 3) begin
            n_fail++;
            $display("FAIL pack4_rate: got %0d valids want 3", nv);
        end
        $display("[TB] pack4: %0d valids in 12 cycles", nv);
    endtask

    task automatic test_pack2_switch();
        int nv;
        logic [DESER-1:0] w0;
        sel = 2'd1;
        all_rand();
        tick();
        nv = 0;
        for (int t = 0; t < 6; t++) begin
            all_rand();
            tick();
            if (o_valid) begin
                nv++;
                n_tests++;
                if (o_data[BEAT-1:2*DESER] !== '0) begin
                    n_fail++;
                    $display("FAIL pack2_upper: got %h want 0", o_data[BEAT-1:2*DESER]);
                end
            end
        end
        n_tests++;
        if (nv != 3) begin
            n_fail++;
            $display("FAIL pack2_rate: got %0d valids want 3", nv);
        end
        all_rand();
        tick();
        sel = 2'd0;
        all_rand();
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_drop: valid got %b want 0", o_valid);
        end
        for (int t = 0; t < 4; t++) begin
            all_rand();
            w0 = rx_data[DESER-1:0];
            tick();
            n_tests++;
            if (o_valid !== 1'b1 || o_data[BEAT-1:0] !== {{(BEAT-DESER){1'b0}}, w0}) begin
                n_fail++;
                $display("FAIL switch_r1 t=%0d: valid %b data %h want 1 %h", t, o_valid, o_data[BEAT-1:0], w0);
            end
        end
        $display("[TB] pack2 and switch to 1-word checked");
    endtask

    task automatic test_rdy_drop();
        rdy = 1'b0;
        all_rand();
        tick();
        mdl_all_locked = 1'b0;
        n_tests++;
        if (o_locked !== '0 || o_all_locked !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_drop: locked %h all %b valid %b want 0", o_locked, o_all_locked, o_valid);
        end
        run_lock("relock_after_rdy");
    endtask

    task automatic test_slip_rotated();
        int rot, pulses, others, last, mingap, premature;
        bit done;
        logic [NCH-1:0] om;
        om = '1;
        om[3] = 1'b0;
        pulse_train();
        rot = 3; pulses = 0; others = 0; last = -1; mingap = 1000; premature = 0; done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            all_pat();
            set_lane(3, rotr(PAT, rot));
            tick();
            if (o_cda[3]) begin
                pulses++;
                if (last >= 0 && (t - last) < mingap) mingap = t - last;
                last = t;
                rot = (rot + DESER - 1) % DESER;
            end
            if ((o_cda & om) != '0) others++;
            if (o_all_locked) premature++;
            if (o_locked[3]) done = 1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL slip_lock: lane 3 locked %b want 1 within 300 cycles", o_locked[3]);
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL slip_count: got %0d pulses want 3", pulses);
        end
        n_tests++;
        if (mingap < SLIP_WAIT + 2) begin
            n_fail++;
            $display("FAIL slip_spacing: got %0d want >= %0d", mingap, SLIP_WAIT + 2);
        end
        n_tests++;
        if (others != 0 || premature != 0) begin
            n_fail++;
            $display("FAIL slip_other: other-lane pulses %0d early all_locked %0d want 0 0", others, premature);
        end
        all_pat();
        tick();
        n_tests++;
        if (o_all_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_all_locked: got %b want 1", o_all_locked);
        end
        mdl_all_locked = 1'b1;
        repeat (3) begin
            all_rand();
            tick();
        end
        $display("[TB] slip: %0d pulses, min gap %0d", pulses, mingap);
    endtask

    task automatic test_fail_lane();
        int pulses, others, seen_all;
        bit done;
        logic [NCH-1:0] om;
        om = '1;
        om[5] = 1'b0;
        pulse_train();
        pulses = 0; others = 0; seen_all = 0; done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            all_pat();
            set_lane(5, 10'h3FF);
            tick();
            if (o_cda[5]) pulses++;
            if ((o_cda & om) != '0) others++;
            if (o_all_locked) seen_all++;
            if (o_fail[5]) done = 1;
        end
        repeat (5) begin
            tick();
            if (o_all_locked) seen_all++;
        end
        n_tests++;
        if (!done || o_fail !== ~om) begin
            n_fail++;
            $display("FAIL fail_flag: got %h want %h", o_fail, ~om);
        end
        n_tests++;
        if (pulses != DESER) begin
            n_fail++;
            $display("FAIL fail_pulses: got %0d want %0d", pulses, DESER);
        end
        n_tests++;
        if (o_locked !== om || others != 0 || seen_all != 0) begin
            n_fail++;
            $display("FAIL fail_others: locked %h others %0d all_locked seen %0d want %h 0 0", o_locked, others, seen_all, om);
        end
        pulse_train();
        run_lock("relock_after_fail");
        $display("[TB] fail lane: %0d pulses", pulses);
    endtask

    task automatic test_train_in_slip();
        int pulses;
        bit seen;
        pulse_train();
        pulses = 0; seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            all_pat();
            set_lane(7, 10'h3FF);
            tick();
            if (o_cda != '0) pulses++;
            if (o_cda[7]) seen = 1;
        end
        n_tests++;
        if (!seen || pulses != 1) begin
            n_fail++;
            $display("FAIL slip_seen: seen %b pulses %0d want 1 1", seen, pulses);
        end
        pulse_train();
        n_tests++;
        if (o_cda !== '0) begin
            n_fail++;
            $display("FAIL train_in_slip: cda got %h want 0", o_cda);
        end
        run_lock("relock_after_train_in_slip");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_lock("initial_lock");
        test_pack4();
        test_pack2_switch();
        test_rdy_drop();
        test_slip_rotated();
        test_fail_lane();
        test_train_in_slip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
